// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM states, grant codes
// and default timing parameters.
package spi_arb_pkg;

   localparam int GUARD_CYCLES_DEFAULT = 8;
   localparam int SYNC_STAGES_DEFAULT  = 2;

   typedef enum logic [2:0] {
      IDLE,
      CTRL,
      WR_WAIT,
      WR_GUARD,
      WR,
      REL_GUARD
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CTRL = 2'b01;
   localparam logic [1:0] GNT_WR   = 2'b10;

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Bundle of request, SPI source and arbitrated flash pin signals shared by
// the arbiter (slave side) and whatever drives it (master side).
interface spi_flash_arbiter_if;

   logic       i_FT_CS;
   logic       i_ctrl_req;
   logic       i_ctrl_spi_clk;
   logic       i_ctrl_spi_mosi;
   logic       i_ctrl_spi_cs;
   logic       i_wr_spi_clk;
   logic       i_wr_spi_mosi;
   logic       i_wr_spi_cs;
   logic       o_SPI_CLK;
   logic       o_SPI_MOSI;
   logic       o_SPI_CS;
   logic [1:0] o_grant;
   logic       o_HALT;
   logic       o_busy;

   modport slave (
      input  i_FT_CS, i_ctrl_req,
      input  i_ctrl_spi_clk, i_ctrl_spi_mosi, i_ctrl_spi_cs,
      input  i_wr_spi_clk, i_wr_spi_mosi, i_wr_spi_cs,
      output o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
      output o_grant, o_HALT, o_busy
   );

   modport master (
      output i_FT_CS, i_ctrl_req,
      output i_ctrl_spi_clk, i_ctrl_spi_mosi, i_ctrl_spi_cs,
      output i_wr_spi_clk, i_wr_spi_mosi, i_wr_spi_cs,
      input  o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
      input  o_grant, o_HALT, o_busy
   );

endinterface

// File: rtl/spi_flash_arbiter_sync.sv
// Multi-flop synchronizer bringing a single asynchronous bit into the clk
// domain; the reset value lets the output start in the "inactive" level.
module bit_synchronizer #(
   parameter int   DEPTH     = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= {DEPTH{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[DEPTH-2:0], d};
      end
   end

   assign q = sync_reg[DEPTH-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates the SPI flash between the 6809 controller and the FT2232 writer,
// holding the bus idle for a guard period on every change of owner.
module spi_flash_arbiter
   import spi_arb_pkg::*;
#(
   parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
   input logic                clk,
   input logic                reset,
   spi_flash_arbiter_if.slave bus
);

   localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

   arb_state_t state;
   logic [7:0] guard_cnt;
   logic       ft_cs_sync;
   logic       ft_req;

   bit_synchronizer #(
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_ft_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.i_FT_CS),
      .q     (ft_cs_sync)
   );

   assign ft_req = ~ft_cs_sync;

   // The writer only ever gets the bus after a full guard; a running
   // controller transaction is allowed to finish first (WR_WAIT).
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bus.o_grant <= GNT_NONE;
         bus.o_busy  <= 1'b0;
         bus.o_HALT  <= 1'b1;
         guard_cnt   <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ft_req) begin
                  state       <= WR_GUARD;
                  bus.o_grant <= GNT_NONE;
                  bus.o_busy  <= 1'b1;
                  guard_cnt   <= GUARD_LOAD;
               end else if (bus.i_ctrl_req) begin
                  state       <= CTRL;
                  bus.o_grant <= GNT_CTRL;
                  bus.o_busy  <= 1'b1;
               end
            end
            CTRL: begin
               if (ft_req) begin
                  state <= WR_WAIT;
               end else if (!bus.i_ctrl_req && bus.i_ctrl_spi_cs) begin
                  state       <= IDLE;
                  bus.o_grant <= GNT_NONE;
                  bus.o_busy  <= 1'b0;
                  bus.o_HALT  <= 1'b1;
               end
            end
            WR_WAIT: begin
               if (bus.i_ctrl_spi_cs && !bus.i_ctrl_req) begin
                  state       <= WR_GUARD;
                  bus.o_grant <= GNT_NONE;
                  guard_cnt   <= GUARD_LOAD;
               end
            end
            WR_GUARD: begin
               if (guard_cnt == 8'd0) begin
                  if (ft_req) begin
                     state       <= WR;
                     bus.o_grant <= GNT_WR;
                  end else begin
                     state     <= REL_GUARD;
                     guard_cnt <= GUARD_LOAD;
                  end
               end else begin
                  guard_cnt <= guard_cnt - 8'd1;
               end
            end
            WR: begin
               if (!ft_req) begin
                  state       <= REL_GUARD;
                  bus.o_grant <= GNT_NONE;
                  guard_cnt   <= GUARD_LOAD;
               end
            end
            REL_GUARD: begin
               if (guard_cnt == 8'd0) begin
                  if (ft_req) begin
                     state     <= WR_GUARD;
                     guard_cnt <= GUARD_LOAD;
                  end else begin
                     state      <= IDLE;
                     bus.o_busy <= 1'b0;
                     bus.o_HALT <= 1'b1;
                  end
               end else begin
                  guard_cnt <= guard_cnt - 8'd1;
               end
            end
            default: begin
               state       <= IDLE;
               bus.o_grant <= GNT_NONE;
               bus.o_busy  <= 1'b0;
               bus.o_HALT  <= 1'b1;
               guard_cnt   <= 8'd0;
            end
         endcase
         if (ft_req) begin
            bus.o_HALT <= 1'b0;
         end
      end
   end

   // With no owner the flash sees a deselected, quiet bus.
   always_comb begin
      bus.o_SPI_CS   = 1'b1;
      bus.o_SPI_CLK  = 1'b0;
      bus.o_SPI_MOSI = 1'b0;
      case (bus.o_grant)
         GNT_CTRL: begin
            bus.o_SPI_CS   = bus.i_ctrl_spi_cs;
            bus.o_SPI_CLK  = bus.i_ctrl_spi_clk;
            bus.o_SPI_MOSI = bus.i_ctrl_spi_mosi;
         end
         GNT_WR: begin
            bus.o_SPI_CS   = bus.i_wr_spi_cs;
            bus.o_SPI_CLK  = bus.i_wr_spi_clk;
            bus.o_SPI_MOSI = bus.i_wr_spi_mosi;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter with default parameters
// (GUARD_CYCLES=8, SYNC_STAGES=2).
module tb_spi_flash_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   assertions = 0;
   int   failures = 0;
   logic [1:0] prev_grant = 2'b00;

   spi_flash_arbiter_if bus();

   spi_flash_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Invariants checked every cycle: no 11 grant, no direct 01->10 handover,
   // and an unowned bus is always deselected and quiet.
   always @(negedge clk) begin
      if (!reset) begin
         assertions++;
         assert (bus.o_grant !== 2'b11) else begin
            failures++;
            $error("[TB] FAIL grant_11: o_grant=%b required not 11", bus.o_grant);
         end
         assertions++;
         assert (!(prev_grant === 2'b01 && bus.o_grant === 2'b10)) else begin
            failures++;
            $error("[TB] FAIL direct_handover: o_grant=%b after %b", bus.o_grant, prev_grant);
         end
         assertions++;
         assert (bus.o_grant !== 2'b00 || (bus.o_SPI_CS === 1'b1 && bus.o_SPI_CLK === 1'b0)) else begin
            failures++;
            $error("[TB] FAIL idle_pins: cs=%b clk=%b required cs=1 clk=0", bus.o_SPI_CS, bus.o_SPI_CLK);
         end
      end
      prev_grant = bus.o_grant;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ft_cs, input logic ctrl_req,
                                input logic c_clk, input logic c_mosi, input logic c_cs,
                                input logic w_clk, input logic w_mosi, input logic w_cs);
      bus.i_FT_CS         = ft_cs;
      bus.i_ctrl_req      = ctrl_req;
      bus.i_ctrl_spi_clk  = c_clk;
      bus.i_ctrl_spi_mosi = c_mosi;
      bus.i_ctrl_spi_cs   = c_cs;
      bus.i_wr_spi_clk    = w_clk;
      bus.i_wr_spi_mosi   = w_mosi;
      bus.i_wr_spi_cs     = w_cs;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] grant,
                              input logic halt, input logic busy, input logic cs);
      assertions++;
      assert (bus.o_grant === grant) else begin
         failures++;
         $error("[TB] FAIL %s grant: got %b required %b", tag, bus.o_grant, grant);
      end
      assertions++;
      assert (bus.o_HALT === halt) else begin
         failures++;
         $error("[TB] FAIL %s halt: got %b required %b", tag, bus.o_HALT, halt);
      end
      assertions++;
      assert (bus.o_busy === busy) else begin
         failures++;
         $error("[TB] FAIL %s busy: got %b required %b", tag, bus.o_busy, busy);
      end
      assertions++;
      assert (bus.o_SPI_CS === cs) else begin
         failures++;
         $error("[TB] FAIL %s spi_cs: got %b required %b", tag, bus.o_SPI_CS, cs);
      end
   endtask

   task automatic checkPins(input string tag, input logic cs, input logic sclk, input logic mosi);
      assertions++;
      assert (bus.o_SPI_CS === cs && bus.o_SPI_CLK === sclk && bus.o_SPI_MOSI === mosi) else begin
         failures++;
         $error("[TB] FAIL %s pins: got cs/clk/mosi=%b%b%b required %b%b%b", tag,
                bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI, cs, sclk, mosi);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
      step(2);
      checkOutput("reset", 2'b00, 1, 0, 1);
      checkPins("reset_pins", 1, 0, 0);
      reset = 1'b0;
      step(1);

      // Controller transaction from idle
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      step(1);
      checkOutput("ctrl_grant", 2'b01, 1, 1, 0);
      checkPins("ctrl_pins", 0, 1, 1);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
      step(14);
      checkOutput("ctrl_hold", 2'b01, 1, 1, 0);
      checkPins("ctrl_pins2", 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 1, 0, 0, 1);
      step(1);
      checkOutput("ctrl_cs_high_req_high", 2'b01, 1, 1, 1);
      step(3);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
      step(1);
      checkOutput("ctrl_release", 2'b00, 1, 0, 1);

      // Writer request on an idle bus
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      step(2);
      checkOutput("wr_sync", 2'b00, 1, 0, 1);
      step(1);
      checkOutput("wr_halt", 2'b00, 0, 1, 1);
      step(7);
      checkOutput("wr_guard_end", 2'b00, 0, 1, 1);
      step(1);
      checkOutput("wr_grant", 2'b10, 0, 1, 0);
      checkPins("wr_pins", 0, 1, 1);

      // Long writer session then release
      step(100);
      checkOutput("wr_long", 2'b10, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 1, 1, 1, 0);
      step(3);
      checkOutput("rel_guard", 2'b00, 0, 1, 1);
      step(7);
      checkOutput("rel_guard_end", 2'b00, 0, 1, 1);
      step(1);
      checkOutput("rel_idle", 2'b00, 1, 0, 1);
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 1);
      step(1);
      checkOutput("ctrl_after_wr", 2'b01, 1, 1, 0);
      checkPins("ctrl_after_wr_pins", 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
      step(1);
      checkOutput("ctrl_done", 2'b00, 1, 0, 1);

      // Writer request in the middle of a controller transfer
      applyStimulus(1, 1, 1, 0, 0, 1, 1, 0);
      step(1);
      checkOutput("mid_ctrl", 2'b01, 1, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 1, 1, 0);
      step(3);
      checkOutput("wr_wait", 2'b01, 0, 1, 0);
      checkPins("wr_wait_pins", 0, 1, 0);
      step(5);
      checkOutput("wr_wait_hold", 2'b01, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      step(1);
      checkOutput("switch_guard", 2'b00, 0, 1, 1);
      step(7);
      checkOutput("switch_guard_end", 2'b00, 0, 1, 1);
      step(1);
      checkOutput("switch_wr", 2'b10, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
      step(11);
      checkOutput("switch_idle", 2'b00, 1, 0, 1);

      // Both requests reach the FSM on the same edge: writer wins
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
      step(2);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
      step(1);
      checkOutput("both_req", 2'b00, 0, 1, 1);
      for (int i = 0; i < 7; i++) begin
         step(1);
         checkOutput("both_guard", 2'b00, 0, 1, 1);
      end
      step(1);
      checkOutput("both_wr", 2'b10, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
      step(11);
      checkOutput("both_idle", 2'b00, 1, 0, 1);

      // Writer request withdrawn during its guard: no writer grant issued
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      step(3);
      checkOutput("abort_guard", 2'b00, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 1, 1, 1, 0);
      step(8);
      checkOutput("abort_no_grant", 2'b00, 0, 1, 1);
      step(7);
      checkOutput("abort_rel", 2'b00, 0, 1, 1);
      step(1);
      checkOutput("abort_idle", 2'b00, 1, 0, 1);

      // Reset while the writer owns the bus
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      step(11);
      checkOutput("rst_pre", 2'b10, 0, 1, 0);
      reset = 1'b1;
      step(1);
      checkOutput("rst_mid", 2'b00, 1, 0, 1);
      checkPins("rst_pins", 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
      step(1);
      reset = 1'b0;
      step(3);
      checkOutput("rst_after", 2'b00, 1, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
